// File: rtl/mem_pkg.sv
// Shared memory-system definitions used by the CPU and ram_1kx20.
// Defaults give a 1024-word by 20-bit unified instruction/data store.
package mem_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 20;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/ram_1kx20.sv
// Single-port synchronous RAM with a registered read port, 1-cycle latency.
// A concurrent store and load to the same word return the new data (write-first).
module ram_1kx20
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write,
   input  logic              str,
   input  logic              ld,
   output logic [DATA_W-1:0] read
);

   // Zero-initialised contents for simulation; the array itself is never reset.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] read_q = '0;

   // One clocked process for BRAM inference; reset touches only read_q.
   // rst_n low acts as an enable gate on the array, not as a clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_q <= '0;
      end else begin
         if (str) begin
            mem[addr] <= write;
         end
         if (ld) begin
            read_q <= str ? write : mem[addr];
         end
      end
   end

   assign read = read_q;

`ifndef SYNTHESIS
   // Unknown strobes fall through the ifs above, leaving state untouched.
   always @(posedge clk) begin
      if (rst_n === 1'b1 && ($isunknown(str) || $isunknown(ld))) begin
         $error("ram_1kx20: unknown str/ld strobe (str=%b ld=%b)", str, ld);
      end
   end
`endif

endmodule

// File: tb/tb_ram_1kx20.sv
// Self-checking bench for ram_1kx20: directed plan plus randomized traffic
// compared against an array-based reference model.
module tb_ram_1kx20;

   localparam int AW = 10;
   localparam int DW = 20;
   localparam int NW = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] addr;
   logic [DW-1:0] write;
   logic          str;
   logic          ld;
   logic [DW-1:0] read;

   int checks = 0;
   int errors = 0;

   // Reference state: memory contents and the value read should currently show.
   logic [DW-1:0] ref_mem [NW];
   logic [DW-1:0] ref_read;

   ram_1kx20 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .write (write),
      .str   (str),
      .ld    (ld),
      .read  (read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%05h) expected %0d (0x%05h) at %0t",
                  tag, obs, obs, exp, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model by the same edge, check read.
   task automatic step(input string tag, input logic r, input logic s, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] w);
      @(negedge clk);
      rst_n = r;
      str   = s;
      ld    = l;
      addr  = a;
      write = w;
      @(posedge clk);
      if (!r) begin
         ref_read = '0;
      end else begin
         if (l) ref_read = s ? w : ref_mem[a];
         if (s) ref_mem[a] = w;
      end
      #1;
      chk(tag, read, ref_read);
   endtask

   initial begin
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      ref_read = '0;
      rst_n = 1'b1;
      str   = 1'b0;
      ld    = 1'b0;
      addr  = '0;
      write = '0;

      #1;
      chk("powerup", read, 20'd0);

      // Reset then idle
      step("rst0", 1'b0, 1'b1, 1'b1, 10'd5, 20'd77);
      step("rst1", 1'b0, 1'b1, 1'b1, 10'd5, 20'd77);
      chk("rst_read", read, 20'd0);
      step("idle_ld5", 1'b1, 1'b0, 1'b1, 10'd5, 20'd0);
      chk("mem5_unwritten", read, 20'd0);

      // Write-first at address 0, then hold
      step("wf0", 1'b1, 1'b1, 1'b1, 10'd0, 20'd101);
      chk("wf0_const", read, 20'd101);
      step("ld0", 1'b1, 1'b0, 1'b1, 10'd0, 20'd0);
      chk("ld0_const", read, 20'd101);

      // Store without load leaves read alone
      step("hold", 1'b1, 1'b1, 1'b0, 10'd1, 20'd999);
      chk("hold_const", read, 20'd101);
      step("rd1", 1'b1, 1'b0, 1'b1, 10'd1, 20'd0);
      chk("rd1_const", read, 20'd999);

      // Burst of write-first accesses
      step("burst1", 1'b1, 1'b1, 1'b1, 10'd1, 20'd202);
      chk("burst1_const", read, 20'd202);
      step("burst2", 1'b1, 1'b1, 1'b1, 10'd2, 20'd303);
      step("burst3", 1'b1, 1'b1, 1'b1, 10'd3, 20'd404);
      step("burst4", 1'b1, 1'b1, 1'b1, 10'd4, 20'd505);
      chk("burst4_const", read, 20'd505);

      // Readback, including the top address
      step("rb3", 1'b1, 1'b0, 1'b1, 10'd3, 20'd0);
      chk("rb3_const", read, 20'd404);
      step("rb2", 1'b1, 1'b0, 1'b1, 10'd2, 20'd0);
      chk("rb2_const", read, 20'd303);
      step("w1023", 1'b1, 1'b1, 1'b0, 10'd1023, 20'hFFFFF);
      step("rb1023", 1'b1, 1'b0, 1'b1, 10'd1023, 20'd0);
      chk("rb1023_const", read, 20'hFFFFF);
      step("rb4", 1'b1, 1'b0, 1'b1, 10'd4, 20'd0);

      // Reset mid-operation suppresses the store; the array survives
      step("midrst", 1'b0, 1'b1, 1'b1, 10'd4, 20'd1);
      chk("midrst_const", read, 20'd0);
      step("after_rst4", 1'b1, 1'b0, 1'b1, 10'd4, 20'd0);
      chk("mem4_kept", read, 20'd505);

      // Randomized traffic over a narrow window plus the array edges
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] w;
         logic r;
         logic s;
         logic l;
         case ($urandom_range(0, 3))
            0:       a = AW'($urandom_range(NW - 4, NW - 1));
            default: a = AW'($urandom_range(0, 15));
         endcase
         w = DW'($urandom);
         r = ($urandom_range(0, 29) != 0);
         s = $urandom_range(0, 1) != 0;
         l = $urandom_range(0, 2) != 0;
         step("rand", r, s, l, a, w);
      end

      // Sweep back everything the random phase could have touched
      for (int i = 0; i < 16; i++) step("sweep_lo", 1'b1, 1'b0, 1'b1, AW'(i), 20'd0);
      for (int i = NW - 4; i < NW; i++) step("sweep_hi", 1'b1, 1'b0, 1'b1, AW'(i), 20'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
